// File: rtl/bram_pingpong_out_buff_pkg.sv
// Shared types and default sizes for the synchroniser output buffers.
//   bank_st_e : per-bank ownership (FREE / FULL / READING)
//   rd_st_e   : reader FSM states
//   BUFF_*    : default sample width / bank depth used across the buffers
package bram_pingpong_out_buff_pkg;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FULL    = 2'd1,
        BANK_READING = 2'd2
    } bank_st_e;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_st_e;

    localparam int BUFF_DATA_W = 8;
    localparam int BUFF_DEPTH  = 768;
    localparam int BUFF_ADDR_W = 10;

endpackage

// File: rtl/bram_pingpong_out_buff_if.sv
// Producer write port + valid/ready output stream + status of the ping-pong buffer.
//   slave  : buffer side (takes writes/commit/m_ready, drives ready/stream/status)
//   master : producer/consumer side
interface bram_pingpong_out_buff_if
    import bram_pingpong_out_buff_pkg::*;
#(
    parameter int DATA_W = BUFF_DATA_W,
    parameter int ADDR_W = BUFF_ADDR_W
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic              wr_ready;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              err;
    logic [1:0]        bank_full;

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, m_ready,
        output wr_ready, m_valid, m_data, m_last, err, bank_full
    );

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, m_ready,
        input  wr_ready, m_valid, m_data, m_last, err, bank_full
    );
endinterface

// File: rtl/bram_sdp_buff.sv
// Simple dual-port RAM, 2^ADDR_W x DATA_W, no reset.
//   we/waddr/wdata : synchronous write port
//   re/raddr/dout  : synchronous read; dout holds while re is low, so it can
//                    act directly as a pipeline output register
module bram_sdp_buff
    import bram_pingpong_out_buff_pkg::*;
#(
    parameter int DATA_W = BUFF_DATA_W,
    parameter int ADDR_W = BUFF_ADDR_W + 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) dout <= mem[raddr];
    end
endmodule

// File: rtl/bram_pingpong_out_buff.sv
// Double-buffered output buffer: producer random-writes one bank while the
// other streams addresses 0..FRAME_LEN-1 over valid/ready.
//   clk, rst_n : clock, async active-low reset
//   bus        : write port (wr_*), stream (m_*), err pulse, bank_full debug
module bram_pingpong_out_buff
    import bram_pingpong_out_buff_pkg::*;
#(
    parameter int DATA_W    = BUFF_DATA_W,
    parameter int DEPTH     = BUFF_DEPTH,
    parameter int ADDR_W    = BUFF_ADDR_W,
    parameter int FRAME_LEN = BUFF_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    bram_pingpong_out_buff_if.slave bus
);
    // One extra bit so DEPTH/FRAME_LEN == 2^ADDR_W still compare correctly.
    localparam int               CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FLEN_C  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(FRAME_LEN - 1);

    bank_st_e          bank_q [2];
    logic              wb_q, rb_q;
    rd_st_e            st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              vld_q, vld_d, last_q, last_d, err_q;
    logic              ready_w, addr_ok, wr_acc, commit, drop, adv;
    logic              rd_en, claim, rel;
    logic [ADDR_W-1:0] rd_addr;

    assign ready_w = (bank_q[wb_q] == BANK_FREE);
    assign addr_ok = ({1'b0, bus.wr_addr} < DEPTH_C);
    assign wr_acc  = bus.wr_en & ready_w & addr_ok;
    assign commit  = bus.wr_commit & ready_w;
    assign drop    = (bus.wr_en & ~(ready_w & addr_ok)) | (bus.wr_commit & ~ready_w);
    assign adv     = ~vld_q | bus.m_ready;

    // Commit and claim/free can never target the same bank in one cycle:
    // commit needs FREE, claim needs FULL, free needs READING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0] <= BANK_FREE;
            bank_q[1] <= BANK_FREE;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= drop;
            if (commit) begin
                bank_q[wb_q] <= BANK_FULL;
                wb_q         <= ~wb_q;
            end
            if (claim) bank_q[rb_q] <= BANK_READING;
            if (rel) begin
                bank_q[rb_q] <= BANK_FREE;
                rb_q         <= ~rb_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= RD_IDLE;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    // cnt_q is the next address to fetch; the RAM dout register is the beat
    // currently presented, so a fetch only happens when that beat moves on.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        last_d  = last_q;
        rd_en   = 1'b0;
        rd_addr = cnt_q[ADDR_W-1:0];
        claim   = 1'b0;
        rel     = 1'b0;
        case (st_q)
            RD_IDLE: begin
                if (bank_q[rb_q] == BANK_FULL) begin
                    claim   = 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    cnt_d   = CNT_W'(1);
                    vld_d   = 1'b1;
                    last_d  = (FRAME_LEN == 1);
                    st_d    = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (adv) begin
                    if (cnt_q < FLEN_C) begin
                        rd_en  = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        vld_d  = 1'b1;
                        last_d = (cnt_q == LAST_C);
                    end else begin
                        vld_d  = 1'b0;
                        last_d = 1'b0;
                    end
                end
                if (vld_q & bus.m_ready & last_q) begin
                    rel  = 1'b1;
                    st_d = RD_IDLE;
                end
            end
            default: st_d = RD_IDLE;
        endcase
    end

    bram_sdp_buff #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr ({wb_q, bus.wr_addr}),
        .wdata (bus.wr_data),
        .re    (rd_en),
        .raddr ({rb_q, rd_addr}),
        .dout  (bus.m_data)
    );

    assign bus.wr_ready  = ready_w;
    assign bus.m_valid   = vld_q;
    assign bus.m_last    = last_q;
    assign bus.err       = err_q;
    assign bus.bank_full = {bank_q[1] != BANK_FREE, bank_q[0] != BANK_FREE};
endmodule

// File: tb/tb_bram_pingpong_out_buff.sv
// Directed bench for bram_pingpong_out_buff: model of bank contents, an
// expected-beat queue filled on each commit, and a negedge stream monitor.
module tb_bram_pingpong_out_buff;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int DP = 768;
    localparam int FL = 768;

    logic clk;
    logic rst_n;
    bram_pingpong_out_buff_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    bram_pingpong_out_buff #(
        .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .FRAME_LEN(FL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mdl [2][DP];
    logic [DW:0]   exp_q [$];
    logic          tb_wb;
    int            beats_seen;
    logic [DW-1:0] last_seen;
    logic          rnd_rdy;
    logic          stall_q;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k, input int a);
        case (k)
            0:       return DW'(a);
            1:       return DW'(a ^ 'h3C);
            2:       return DW'(a * 7);
            6:       return DW'(a ^ 'h5A);
            7:       return DW'(a + 9);
            8:       return DW'(a ^ 'hC3);
            default: return DW'(a * 3 + k * 17 + 1);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_commit = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.m_ready   = 1'b0;
        exp_q.delete();
        tb_wb      = 1'b0;
        beats_seen = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits for a free write bank, then writes addresses 0..n-1 with pattern k.
    task automatic fill(input int k, input int n);
        int w;
        w = 0;
        while (!bus.wr_ready && w < 5000) begin
            tick();
            w++;
        end
        chk("fill_ready", bus.wr_ready, 1);
        for (int a = 0; a < n; a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(a);
            bus.wr_data = pat(k, a);
            mdl[tb_wb][a] = pat(k, a);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    // Commit (optionally with a same-cycle write) and queue the frame it hands over.
    task automatic commit(input logic with_wr, input int a, input logic [DW-1:0] d);
        bus.wr_commit = 1'b1;
        if (with_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(a);
            bus.wr_data = d;
            mdl[tb_wb][a] = d;
        end
        tick();
        bus.wr_commit = 1'b0;
        bus.wr_en     = 1'b0;
        for (int i = 0; i < FL; i++) exp_q.push_back({i == FL - 1, mdl[tb_wb][i]});
        tb_wb = ~tb_wb;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && w < 20000) begin
            tick();
            w++;
        end
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_valid_low"}, bus.m_valid, 0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Stream monitor: each accepted beat is compared to the queue head, and a
    // stalled beat must be presented unchanged on the following cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", bus.m_valid, 1);
                chk("hold_data", bus.m_data, hold_data);
                chk("hold_last", bus.m_last, hold_last);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", bus.m_valid, 0);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("beat_data", bus.m_data, e[DW-1:0]);
                    chk("beat_last", bus.m_last, e[DW]);
                end
                beats_seen++;
                last_seen = bus.m_data;
            end
            stall_q   = bus.m_valid && !bus.m_ready;
            hold_data = bus.m_data;
            hold_last = bus.m_last;
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            bus.m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rnd_rdy = 1'b0;
        stall_q = 1'b0;
        do_reset();

        // Reset state
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_bank_full", bus.bank_full, 0);

        // Single frame, data = addr[7:0], m_ready held high
        bus.m_ready = 1'b1;
        fill(0, DP);
        commit(1'b0, 0, '0);
        chk("t1_valid_c1", bus.m_valid, 0);
        chk("t1_bank_full_c1", bus.bank_full, 1);
        chk("t1_wr_ready", bus.wr_ready, 1);
        tick();
        chk("t1_valid_c2", bus.m_valid, 1);
        chk("t1_first_data", bus.m_data, 0);
        drain("t1");
        chk("t1_bank_full_end", bus.bank_full, 0);
        chk("t1_last_data", last_seen, 8'hFF);

        // Both banks full under backpressure; dropped write and commit
        do_reset();
        fill(1, DP);
        commit(1'b0, 0, '0);
        fill(2, DP);
        commit(1'b0, 0, '0);
        chk("t2_wr_ready_low", bus.wr_ready, 0);
        chk("t2_bank_full", bus.bank_full, 3);
        chk("t2_valid", bus.m_valid, 1);
        chk("t2_head", bus.m_data, pat(1, 0));
        chk("t2_err_pre", bus.err, 0);
        wr(5, 8'hEE);
        chk("t2_err_drop_wr", bus.err, 1);
        tick();
        chk("t2_err_clear", bus.err, 0);
        bus.wr_commit = 1'b1;
        tick();
        bus.wr_commit = 1'b0;
        chk("t2_err_drop_commit", bus.err, 1);
        chk("t2_bank_full_keep", bus.bank_full, 3);
        bus.m_ready = 1'b1;
        w = 0;
        while (!(bus.m_valid && bus.m_last) && w < 2000) begin
            tick();
            w++;
        end
        chk("t2_last_seen", bus.m_last, 1);
        chk("t2_ready_before", bus.wr_ready, 0);
        tick();
        chk("t2_ready_rise", bus.wr_ready, 1);
        drain("t2");

        // Three frames with random backpressure
        do_reset();
        rnd_rdy = 1'b1;
        fill(3, DP);
        commit(1'b0, 0, '0);
        fill(4, DP);
        commit(1'b0, 0, '0);
        fill(5, DP);
        commit(1'b0, 0, '0);
        drain("t3");
        rnd_rdy = 1'b0;
        tick();

        // Write at the last address in the same cycle as commit
        do_reset();
        bus.m_ready = 1'b1;
        fill(6, DP - 1);
        commit(1'b1, DP - 1, 8'hA5);
        drain("t4");
        chk("t4_last_beat", last_seen, 8'hA5);

        // Out-of-range write address
        chk("t5_err_pre", bus.err, 0);
        wr(800, 8'h77);
        chk("t5_err", bus.err, 1);
        chk("t5_wr_ready", bus.wr_ready, 1);
        chk("t5_bank_full", bus.bank_full, 0);
        tick();
        chk("t5_err_clear", bus.err, 0);

        // Reset in the middle of a frame, then a fresh frame
        do_reset();
        bus.m_ready = 1'b1;
        fill(7, DP);
        commit(1'b0, 0, '0);
        w = 0;
        while (beats_seen < 300 && w < 2000) begin
            tick();
            w++;
        end
        chk("t6_beat300", bus.m_data, pat(7, 300));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.m_valid, 0);
        chk("t6_rst_wr_ready", bus.wr_ready, 1);
        chk("t6_rst_bank_full", bus.bank_full, 0);
        exp_q.delete();
        tb_wb      = 1'b0;
        beats_seen = 0;
        tick();
        rst_n = 1'b1;
        tick();
        fill(8, DP);
        commit(1'b0, 0, '0);
        drain("t6");
        chk("t6_beats", beats_seen, FL);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_pingpong_out_buff.md
Name: bram_pingpong_out_buff

Overview:
- Parametrised double-buffered (ping-pong) output buffer for the time-synchroniser data path.
- The producer fills one BRAM bank by random-access address while the other bank streams out in address order over a valid/ready interface.
- Banks swap on an explicit commit, so a full frame can be written while the previous one drains.
- Successor to the single-bank 8x768 output buffer; adds width/depth/frame parameters, two banks, backpressure and error flagging.

Parameters:
- DATA_W, 8, sample width in bits.
- DEPTH, 768, entries per bank; legal write addresses are 0..DEPTH-1.
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= DEPTH.
- FRAME_LEN, 768, beats streamed per committed bank; must satisfy 1 <= FRAME_LEN <= DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe into the current write bank.
- wr_addr  in  ADDR_W  write address within the bank.
- wr_data  in  DATA_W  write data.
- wr_commit  in  1  one-cycle pulse: the current write bank is complete; hand it to the reader.
- wr_ready  out  1  current write bank is FREE; writes and commit are accepted.
- m_valid  out  1  output beat valid.
- m_ready  in  1  consumer accepts the beat.
- m_data  out  DATA_W  output sample; don't-care while m_valid=0.
- m_last  out  1  high with the beat at address FRAME_LEN-1.
- err  out  1  one-cycle pulse on a dropped write or dropped commit.
- bank_full  out  2  per-bank FULL-or-READING status, for debug.

Behaviour:
- Bank state: each bank is FREE, FULL or READING. Write pointer wb, read pointer rb.
- Reset: both banks FREE; wb=rb=0; reader in IDLE; wr_ready=1; m_valid=0; m_last=0; err=0. BRAM contents are not cleared. m_data carries no reset, so BRAM output-register inference is preserved.
- Write: when wr_en & wr_ready & wr_addr<DEPTH, write mem[{wb,wr_addr}]=wr_data.
  - If wr_en & (!wr_ready | wr_addr>=DEPTH): the write is dropped, err=1 on the next cycle.
- Commit: when wr_commit & wr_ready, bank[wb]<=FULL and wb toggles.
  - wr_en together with wr_commit in the same cycle: the data lands in the old bank before the switch.
  - wr_commit with !wr_ready: the commit is dropped and err pulses.
- wr_ready = (bank[wb]==FREE), combinational from registered state.
- Reader FSM, IDLE:
  - If bank[rb]==FULL: bank[rb]<=READING, issue a BRAM read of address 0, rd_cnt<=1, go to STREAM.
- Reader FSM, STREAM:
  - adv = !m_valid | m_ready.
  - On adv with rd_cnt<FRAME_LEN: read address rd_cnt, rd_cnt++, m_valid<=1, m_last<=(rd_cnt==FRAME_LEN-1).
  - On adv with rd_cnt==FRAME_LEN: m_valid<=0.
  - On m_valid & m_ready & m_last: bank[rb]<=FREE, rb toggles, go to IDLE.
- BRAM read port:
  - Read enable = FSM read issue. The dout register holds its value when the enable is low, so it serves as the output stage.
  - m_data is the BRAM dout.
- Latency: commit at cycle t → bank FULL at t+1 → IDLE issues the read at t+1 → m_valid=1 at t+2.
- Throughput: 1 beat per cycle with m_ready held high. There is one idle cycle between frames, spent re-entering IDLE.
- Backpressure: while m_valid & !m_ready, m_data, m_last and rd_cnt hold. No beat is lost or duplicated.
- Simultaneous events: a commit of bank X and the free of bank Y in the same cycle both take effect. If the reader frees the bank that wb points to, wr_ready rises the next cycle.
- Both banks full: wr_ready=0 until the reader frees a bank.
- wr_addr is unrestricted in order; the reader always streams addresses 0..FRAME_LEN-1.
- Reset asserted mid-frame: all state clears immediately and the partial frame is discarded.

Decomposition:
- Shared package:
  - bank-state encoding (FREE=2'd0, FULL=2'd1, READING=2'd2);
  - reader FSM state encoding (IDLE, STREAM);
  - the default DATA_W/DEPTH constants used across the synchroniser buffers.
- Sub-module bram_sdp_buff, a simple dual-port RAM:
  - 2^(ADDR_W+1) x DATA_W;
  - write port with we and address;
  - read port with en, address and a registered dout;
  - no reset.
  - Instantiated once, with the bank select as the address MSB.

Test Plan:
- Reset, then write 0..767 with data=addr[7:0] into bank 0, commit, m_ready=1 → wr_ready stays 1 (bank 1 free); beats 0x00..0xFF repeating, 768 beats; m_last only on beat 767; first m_valid 2 cycles after commit.
- Fill and commit both banks with m_ready=0 → wr_ready=0. A further wr_en gives an err pulse and memory is unchanged. Set m_ready=1 → bank 0 drains, wr_ready rises the cycle after its last beat is accepted.
- Random m_ready (50% duty) over 3 frames → output sequence matches the written data exactly; m_data holds while m_valid & !m_ready.
- wr_en and wr_commit in the same cycle at addr 767, data 0xA5 → the last beat of that frame is 0xA5.
- wr_addr=800 with wr_en → err pulses one cycle later, no write, wr_ready unaffected.
- rst_n low for 1 cycle during beat 300 → m_valid=0 and wr_ready=1 immediately; a fresh frame afterwards streams correctly from address 0.
